// File: rtl/fifo_32_to_8.sv
// Width-converting FIFO: accepts 4-byte words, returns single bytes in write order.
// Each byte slot carries an even-parity bit that is checked when the byte is read.
module fifo_32_to_8 #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 2 ** ADDR_WIDTH,
  parameter int unsigned WRITE_WIDTH = 4 * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WRITE_WIDTH-1:0] w_data,
  input  logic                   wr_en,
  input  logic                   err_inject,
  output logic                   full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  r_data,
  output logic                   empty,
  output logic [DEPTH-1:0]       status_reg,
  output logic                   parity_error
);

  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_d;
  logic [CountWidth-1:0] count, count_d;
  logic [DEPTH-1:0]      status_d;
  logic                  wr_ok, rd_ok;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      par_mem;

  assign full  = count > CountWidth'(DEPTH - 4);
  assign empty = count == '0;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    status_d = status_reg;
    count_d  = count + (wr_ok ? CountWidth'(4) : '0) - (rd_ok ? CountWidth'(1) : '0);
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr == ADDR_WIDTH'(DEPTH - 4)) ? '0 : wr_ptr + ADDR_WIDTH'(4);
      for (int i = 0; i < 4; i++) begin
        status_d[wr_ptr + ADDR_WIDTH'(i)] = 1'b1;
      end
    end
    if (rd_ok) begin
      rd_ptr_d           = (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      status_d[rd_ptr]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      status_reg   <= '0;
      r_data       <= '0;
      parity_error <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      status_reg <= status_d;
      if (rd_ok) begin
        r_data       <= mem[rd_ptr];
        parity_error <= (^mem[rd_ptr]) ^ par_mem[rd_ptr];
      end
    end
  end

  // Storage has no reset; its contents only matter once status marks a slot occupied.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        mem[wr_ptr + ADDR_WIDTH'(i)]     <= w_data[i*DATA_WIDTH +: DATA_WIDTH];
        par_mem[wr_ptr + ADDR_WIDTH'(i)] <= (^w_data[i*DATA_WIDTH +: DATA_WIDTH])
                                            ^ ((i == 0) && err_inject);
      end
    end
  end

endmodule
